// File: rtl/wb_master_arbiter_if.sv
// Bundles the per-master Wishbone request ports, the single interconnect port and status outputs.
interface wb_master_arbiter_if #(
    parameter int unsigned NM = 2,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    localparam int unsigned SW = DW / 8;

    // Per-master side
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;

    // Interconnect side
    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_we_o;
    logic [SW-1:0]    s_sel_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack_i;

    // Status
    logic [NM-1:0]    grant_o;
    logic             timeout_o;

    // Arbiter view: it is the bus master towards the interconnect.
    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
               s_dat_o, grant_o, timeout_o
    );

    // Environment view: drives masters and the slave response, observes everything else.
    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
               s_dat_o, grant_o, timeout_o
    );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter: holds grant for a whole CYC and converts a
// missing slave ACK into a one-cycle ERR to the owning master.
module wb_master_arbiter #(
    parameter int unsigned NM      = 2,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    wb_master_arbiter_if.master bus
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned LW = $clog2(NM);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [NM-1:0] ONE_HOT0 = {{(NM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [LW-1:0]   last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic [NM-1:0]   req_c;
    logic [LW:0]     rr_idx_c;
    logic [LW-1:0]   pick_c;
    logic            pick_vld_c;
    logic            gcyc_c;
    logic            gstb_c;

    // The last-grant pointer doubles as the owner index while BUSY/ERR.
    assign gcyc_c       = bus.m_cyc_i[last_q];
    assign gstb_c       = bus.m_stb_i[last_q];
    assign bus.grant_o  = grant_q;
    assign bus.m_dat_o  = bus.s_dat_i;

    // Round-robin scan: first requester starting after the last granted master.
    always_comb begin
        req_c      = bus.m_cyc_i & bus.m_stb_i;
        pick_c     = '0;
        pick_vld_c = 1'b0;
        rr_idx_c   = '0;
        for (int unsigned i = 1; i <= NM; i++) begin
            rr_idx_c = {1'b0, last_q} + (LW+1)'(i);
            if (rr_idx_c >= (LW+1)'(NM)) begin
                rr_idx_c = rr_idx_c - (LW+1)'(NM);
            end
            if (!pick_vld_c && req_c[LW'(rr_idx_c)]) begin
                pick_vld_c = 1'b1;
                pick_c     = LW'(rr_idx_c);
            end
        end
    end

    // Next-state, grant, pointer and timeout counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_vld_c) begin
                    grant_d = ONE_HOT0 << pick_c;
                    last_d  = pick_c;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!gcyc_c) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (gstb_c && !bus.s_ack_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_ERR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_ERR: begin
                cnt_d = '0;
                if (gcyc_c) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus outputs: owner payload mux, zero-latency ACK forwarding, ERR pulse.
    always_comb begin
        bus.s_cyc_o   = 1'b0;
        bus.s_stb_o   = 1'b0;
        bus.s_we_o    = 1'b0;
        bus.s_sel_o   = '0;
        bus.s_adr_o   = '0;
        bus.s_dat_o   = '0;
        bus.m_ack_o   = '0;
        bus.m_err_o   = '0;
        bus.timeout_o = 1'b0;
        unique case (state_q)
            ST_BUSY: begin
                bus.s_cyc_o = 1'b1;
                bus.s_stb_o = gstb_c;
                bus.s_we_o  = bus.m_we_i[last_q];
                bus.s_sel_o = bus.m_sel_i[last_q*SW +: SW];
                bus.s_adr_o = bus.m_adr_i[last_q*AW +: AW];
                bus.s_dat_o = bus.m_dat_i[last_q*DW +: DW];
                bus.m_ack_o = grant_q & {NM{bus.s_ack_i & gstb_c}};
            end
            ST_ERR: begin
                bus.s_cyc_o   = 1'b1;
                bus.s_we_o    = bus.m_we_i[last_q];
                bus.s_sel_o   = bus.m_sel_i[last_q*SW +: SW];
                bus.s_adr_o   = bus.m_adr_i[last_q*AW +: AW];
                bus.s_dat_o   = bus.m_dat_i[last_q*DW +: DW];
                bus.m_err_o   = grant_q;
                bus.timeout_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State register; pointer resets to the last master so master 0 wins first.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LW'(NM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter with two masters and TIMEOUT=8.
module tb_wb_master_arbiter;
    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    wb_master_arbiter_if #(.NM(2), .DW(32), .AW(32)) bus ();

    wb_master_arbiter #(.NM(2), .DW(32), .AW(32), .TIMEOUT(8)) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_sel_i = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hA5A5_5A5A;
        tick();
        n_tests++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", bus.grant_o); end
        n_tests++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb: got %b%b want 00", bus.s_cyc_o, bus.s_stb_o); end
        n_tests++; if (bus.m_ack_o !== 2'b00 || bus.m_err_o !== 2'b00 || bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: ack %b err %b to %b want 0", bus.m_ack_o, bus.m_err_o, bus.timeout_o); end
        n_tests++; if (bus.s_adr_o !== 32'h0 || bus.s_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_payload: adr %h dat %h want 0", bus.s_adr_o, bus.s_dat_o); end
        n_tests++; if (bus.m_dat_o !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL reset_mdat: got %h want a5a55a5a", bus.m_dat_o); end
        clear_inputs();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_single_read();
        bus.m_cyc_i[0] = 1'b1;
        bus.m_stb_i[0] = 1'b1;
        bus.m_sel_i[3:0] = 4'hF;
        bus.m_adr_i[31:0] = 32'h0000_1000;
        #1;
        n_tests++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_latency: grant %b cyc %b want 00/0", bus.grant_o, bus.s_cyc_o); end
        tick();
        n_tests++; if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL rd_grant: got %b want 01", bus.grant_o); end
        n_tests++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.s_adr_o !== 32'h0000_1000 || bus.s_sel_o !== 4'hF) begin n_fail++; $display("FAIL rd_bus: cyc %b stb %b adr %h sel %h", bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o, bus.s_sel_o); end
        n_tests++; if (bus.m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rd_noack: got %b want 00", bus.m_ack_o); end
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (bus.m_ack_o !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got %b want 01", bus.m_ack_o); end
        n_tests++; if (bus.m_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", bus.m_dat_o); end
        tick();
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i[0] = 1'b0;
        bus.m_stb_i[0] = 1'b0;
        #1;
        n_tests++; if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL rd_hold: got %b want 01", bus.grant_o); end
        tick();
        n_tests++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_release: grant %b cyc %b want 00/0", bus.grant_o, bus.s_cyc_o); end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_g;
        int         owner;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            owner = k % 2;
            exp_g = (owner == 0) ? 2'b01 : 2'b10;
            bus.m_cyc_i = 2'b11;
            bus.m_stb_i = 2'b11;
            tick();
            n_tests++; if (bus.grant_o !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.grant_o, exp_g); end
            bus.s_ack_i = 1'b1;
            #1;
            n_tests++; if (bus.m_ack_o !== exp_g) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", k, bus.m_ack_o, exp_g); end
            tick();
            bus.s_ack_i = 1'b0;
            bus.m_cyc_i[owner] = 1'b0;
            bus.m_stb_i[owner] = 1'b0;
            tick();
            n_tests++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rr_gap[%0d]: grant %b cyc %b want 00/0", k, bus.grant_o, bus.s_cyc_o); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] adr;
        logic [31:0] dat;
        bus.m_cyc_i[1] = 1'b1;
        bus.m_stb_i[1] = 1'b1;
        bus.m_we_i[1]  = 1'b1;
        bus.m_sel_i[7:4] = 4'h3;
        bus.m_adr_i[31:0] = 32'h0000_3000;
        bus.m_dat_i[31:0] = 32'h0000_0BAD;
        tick();
        n_tests++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL b2b_grant: got %b want 10", bus.grant_o); end
        bus.m_cyc_i[0] = 1'b1;
        bus.m_stb_i[0] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            adr = 32'h0000_2000 + 32'(4 * b);
            dat = 32'h1111_0000 + 32'(b);
            bus.m_adr_i[63:32] = adr;
            bus.m_dat_i[63:32] = dat;
            bus.s_ack_i = 1'b1;
            #1;
            n_tests++; if (bus.s_adr_o !== adr || bus.s_dat_o !== dat) begin n_fail++; $display("FAIL b2b_payload[%0d]: adr %h dat %h want %h %h", b, bus.s_adr_o, bus.s_dat_o, adr, dat); end
            n_tests++; if (bus.s_we_o !== 1'b1 || bus.s_sel_o !== 4'h3 || bus.m_ack_o !== 2'b10) begin n_fail++; $display("FAIL b2b_ctl[%0d]: we %b sel %h ack %b want 1 3 10", b, bus.s_we_o, bus.s_sel_o, bus.m_ack_o); end
            tick();
        end
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i[1] = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        #1;
        n_tests++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL b2b_nopreempt: got %b want 10", bus.grant_o); end
        tick();
        n_tests++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL b2b_gap: got %b want 00", bus.grant_o); end
        tick();
        n_tests++; if (bus.grant_o !== 2'b01 || bus.s_adr_o !== 32'h0000_3000) begin n_fail++; $display("FAIL b2b_next: grant %b adr %h want 01 00003000", bus.grant_o, bus.s_adr_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        bus.m_cyc_i[0] = 1'b1;
        bus.m_stb_i[0] = 1'b1;
        bus.m_adr_i[31:0] = 32'hDEAD_0000;
        tick();
        for (int c = 0; c < 8; c++) begin
            n_tests++; if (bus.s_stb_o !== 1'b1 || bus.m_err_o !== 2'b00 || bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d]: stb %b err %b to %b want 1 00 0", c, bus.s_stb_o, bus.m_err_o, bus.timeout_o); end
            tick();
        end
        n_tests++; if (bus.m_err_o !== 2'b01 || bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_err: err %b to %b want 01 1", bus.m_err_o, bus.timeout_o); end
        n_tests++; if (bus.s_stb_o !== 1'b0 || bus.s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL to_bus: stb %b cyc %b want 0 1", bus.s_stb_o, bus.s_cyc_o); end
        tick();
        n_tests++; if (bus.m_err_o !== 2'b00 || bus.timeout_o !== 1'b0 || bus.s_stb_o !== 1'b1 || bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL to_retry: err %b to %b stb %b grant %b", bus.m_err_o, bus.timeout_o, bus.s_stb_o, bus.grant_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_ack_at_limit();
        bus.m_cyc_i[0] = 1'b1;
        bus.m_stb_i[0] = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hCAFE_F00D;
        #1;
        n_tests++; if (bus.m_ack_o !== 2'b01 || bus.m_err_o !== 2'b00 || bus.m_dat_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lim_ack: ack %b err %b dat %h", bus.m_ack_o, bus.m_err_o, bus.m_dat_o); end
        tick();
        bus.s_ack_i = 1'b0;
        #1;
        n_tests++; if (bus.m_err_o !== 2'b00 || bus.timeout_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin n_fail++; $display("FAIL lim_noerr: err %b to %b stb %b", bus.m_err_o, bus.timeout_o, bus.s_stb_o); end
        for (int c = 0; c < 8; c++) tick();
        bus.s_ack_i = 1'b1;
        #1;
        n_tests++; if (bus.m_err_o !== 2'b01 || bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL lim_err: err %b to %b want 01 1", bus.m_err_o, bus.timeout_o); end
        n_tests++; if (bus.m_ack_o !== 2'b00) begin n_fail++; $display("FAIL lim_lateack: got %b want 00", bus.m_ack_o); end
        clear_inputs();
        tick();
        n_tests++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL lim_idle: grant %b cyc %b", bus.grant_o, bus.s_cyc_o); end
    endtask

    task automatic test_reset_mid_transfer();
        bus.m_cyc_i[0] = 1'b1;
        bus.m_stb_i[0] = 1'b1;
        bus.m_adr_i[31:0] = 32'h0000_4444;
        tick();
        bus.s_ack_i = 1'b1;
        #1;
        n_tests++; if (bus.s_cyc_o !== 1'b1 || bus.m_ack_o !== 2'b01) begin n_fail++; $display("FAIL mid_pre: cyc %b ack %b want 1 01", bus.s_cyc_o, bus.m_ack_o); end
        rstn = 1'b0;
        #1;
        n_tests++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL mid_drop: cyc %b stb %b grant %b", bus.s_cyc_o, bus.s_stb_o, bus.grant_o); end
        n_tests++; if (bus.m_ack_o !== 2'b00 || bus.m_err_o !== 2'b00 || bus.s_adr_o !== 32'h0) begin n_fail++; $display("FAIL mid_quiet: ack %b err %b adr %h", bus.m_ack_o, bus.m_err_o, bus.s_adr_o); end
        tick();
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        rstn = 1'b1;
        #1;
        n_tests++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL mid_release: got %b want 00", bus.grant_o); end
        tick();
        n_tests++; if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL mid_first: got %b want 01", bus.grant_o); end
        clear_inputs();
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_rr_fairness();
        test_back_to_back();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_transfer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
